wakeup_select_matrix: RTL and testbench
=======================================

# wakeup_select_matrix

Parametrised reservation-station scheduler for the backend: allocates RS entries at dispatch, tracks producer→consumer dependencies in an entry-indexed matrix, speculatively wakes consumers a producer-latency after the producer is granted, and selects one ready entry per functional unit each cycle. It sits between dispatch and the FU issue ports, with completion feedback from execute. It generalises entry count, FU count, source count and latency width. It adds per-FU stall, flush, occupancy reporting and optional load-miss replay.

## Interface
- NUM_ENTRIES, 16, RS entries (≥2); IDX_W = $clog2(NUM_ENTRIES)
- NUM_FUS, 4, functional units / select ports; FU_W = $clog2(NUM_FUS) (min 1)
- NUM_SRCS, 2, source operands per dispatched op
- LAT_W, 4, producer latency width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- flush  in  1  drop all entries next edge
- disp_valid  in  1  dispatch request
- disp_ready  out  1  a free entry exists
- disp_idx  out  IDX_W  entry that will be written (lowest free index)
- disp_fu  in  FU_W  target FU
- disp_lat  in  LAT_W  result latency of this op (0 treated as 1)
- disp_src_en  in  NUM_SRCS  source has an in-flight RS producer
- disp_src_tag  in  NUM_SRCS*IDX_W  producer entry index per source
- fu_stall  in  NUM_FUS  FU cannot accept an issue this cycle
- grant_valid  out  NUM_FUS  entry issued to FU f this cycle
- grant_idx  out  NUM_FUS*IDX_W  issued entry per FU
- free_valid  in  NUM_FUS  execute completion, one per FU
- free_idx  in  NUM_FUS*IDX_W  entry completing
- occupancy  out  $clog2(NUM_ENTRIES+1)  count of valid entries, registered
- cancel_valid / cancel_idx  in  1 / IDX_W  producer replay (WAKEUP_REPLAY_EN only)

## Operation
- Per-entry state: valid, issued, woken, fu, lat, countdown, dep[NUM_ENTRIES].
- Dispatch accepted when disp_valid & disp_ready. Entry disp_idx is written at the edge: valid=1, issued=0, woken=0. dep[p]=1 for each enabled source tag p, but only if entry p is valid, not woken and not waking this cycle. Otherwise that bit is 0.
- Ready(e) = valid & ~issued & (dep==0).
- Select: per FU f with ~fu_stall[f], grant the lowest-index ready entry with fu==f. Selection is combinational from registered state. A granted entry sets issued=1 at the edge.
- Wakeup: a grant of p with latency L (L=0→1) makes p's dependents ready exactly L cycles later. Column p is cleared in every row and woken[p] is set when p's countdown expires.
- Free: free_valid[f] clears valid/issued of free_idx. It also forces column clear and woken. Up to NUM_FUS frees per cycle; the same index on two ports is illegal.
- Flush: all valid, issued and countdowns are cleared at the edge. Flush has priority over dispatch, grant and free in the same cycle.
- occupancy = popcount(valid), registered, updated at the same edge as the state change.

## Timing
- Reset (rst=0 at an edge) clears all state. Reset values: disp_ready=0 while rst=0 and 1 from the first cycle after; disp_idx=0, grant_valid=0, grant_idx=0, occupancy=0.
- Dispatch in cycle T: the entry is eligible for grant in T+1 at the earliest.
- Producer granted in T with L=1: a dependent can be granted in T+1 (back-to-back). With L=3, the earliest dependent grant is T+3.
- An entry freed in T is allocatable in T+1, not in T.
- If a dispatch source tag equals a producer whose wake fires in the same cycle, the bit is not set and the consumer is ready in T+1.
- Full: disp_ready=0. A disp_valid asserted while disp_ready=0 is ignored, with no state change.
- A stalled FU gets grant_valid=0. Its ready entries stay ready with no loss of eligibility.

## Configuration
- WAKEUP_REPLAY_EN defined: adds the cancel port and a shadow matrix sdep, which holds original dependencies until the entry is freed.
  - cancel_valid for p sets issued[p]=0, woken[p]=0 and aborts p's countdown.
  - For every valid e with sdep[e][p]=1, it sets dep[e][p]=1 and issued[e]=0, and aborts e's countdown.
  - Replay is single-level. cancel for p is legal only up to L+1 cycles after p's grant.
  - Cancel wins over a grant or wake of the same entry in the same cycle.
- Undefined: no cancel port and no sdep storage. Wakeup is final.

## Test plan
- Reset then fill: 16 dispatches with no deps, no stalls, NUM_FUS=4 → disp_idx 0..15, disp_ready=0 after the 16th, occupancy=16; extra disp_valid ignored.
- Chain: entry 0 (fu0, lat 1) granted in cycle T, entry 1 depends on 0 → entry 1 granted in T+1. Repeat with lat 3 → grant in T+3.
- Same-cycle race: dispatch with tag 2 in the cycle entry 2's wake fires → dep not set; consumer granted the next cycle.
- Stall/priority: entries 3 and 5 ready for fu1, fu_stall[1]=1 for 2 cycles → no grant; on release, grant_idx=3 first, then 5.
- Free/flush: free entries 4 and 9 on two ports in the same cycle → occupancy drops by 2 and both are reallocatable next cycle. Flush while 10 entries are valid → occupancy=0 next cycle, no grants.
- Replay (WAKEUP_REPLAY_EN): load 0 (lat 3) granted, dependent 1 granted at T+3, cancel 0 at T+3 → 1 not issued, dep[1][0]=1; regrant 0, then 1 issues 3 cycles later.

Source files
------------

// File: rtl/wakeup_select_matrix_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wakeup_select_matrix_if : dispatch / issue / completion bus of the RS     |
// | Rev 1.0 ; cancel_valid/cancel_idx exist only when WAKEUP_REPLAY_EN is set |
// +--------------------------------------------------------------------------+
interface wakeup_select_matrix_if #(
  parameter int NUM_ENTRIES = 16,
  parameter int NUM_FUS     = 4,
  parameter int NUM_SRCS    = 2,
  parameter int LAT_W       = 4
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int FU_W  = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;
  localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

  logic                         flush;
  logic                         disp_valid;
  logic                         disp_ready;
  logic [IDX_W-1:0]             disp_idx;
  logic [FU_W-1:0]              disp_fu;
  logic [LAT_W-1:0]             disp_lat;
  logic [NUM_SRCS-1:0]          disp_src_en;
  logic [NUM_SRCS*IDX_W-1:0]    disp_src_tag;
  logic [NUM_FUS-1:0]           fu_stall;
  logic [NUM_FUS-1:0]           grant_valid;
  logic [NUM_FUS*IDX_W-1:0]     grant_idx;
  logic [NUM_FUS-1:0]           free_valid;
  logic [NUM_FUS*IDX_W-1:0]     free_idx;
  logic [OCC_W-1:0]             occupancy;
`ifdef WAKEUP_REPLAY_EN
  logic                         cancel_valid;
  logic [IDX_W-1:0]             cancel_idx;
`endif

  modport master (
    output flush, disp_valid, disp_fu, disp_lat, disp_src_en, disp_src_tag,
    output fu_stall, free_valid, free_idx,
    input  disp_ready, disp_idx, grant_valid, grant_idx, occupancy
`ifdef WAKEUP_REPLAY_EN
    , output cancel_valid, cancel_idx
`endif
  );

  modport slave (
    input  flush, disp_valid, disp_fu, disp_lat, disp_src_en, disp_src_tag,
    input  fu_stall, free_valid, free_idx,
    output disp_ready, disp_idx, grant_valid, grant_idx, occupancy
`ifdef WAKEUP_REPLAY_EN
    , input cancel_valid, cancel_idx
`endif
  );
endinterface
`default_nettype wire

// File: rtl/wakeup_select_matrix.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wakeup_select_matrix : RS alloc, dependency-matrix wakeup, per-FU select  |
// | Rev 1.0 ; WAKEUP_REPLAY_EN adds producer cancel with shadow matrix replay |
// +--------------------------------------------------------------------------+
module wakeup_select_matrix #(
  parameter int NUM_ENTRIES = 16,
  parameter int NUM_FUS     = 4,
  parameter int NUM_SRCS    = 2,
  parameter int LAT_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  wakeup_select_matrix_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int FU_W  = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;
  localparam int OCC_W = $clog2(NUM_ENTRIES + 1);
  localparam logic [LAT_W-1:0] C_LAT_ONE = LAT_W'(1);

  typedef logic [NUM_ENTRIES-1:0] row_t;

  row_t             r_valid, r_issued, r_woken;
  row_t             r_dep [NUM_ENTRIES];
  logic [FU_W-1:0]  r_fu  [NUM_ENTRIES];
  logic [LAT_W-1:0] r_lat [NUM_ENTRIES];
  logic [LAT_W-1:0] r_cd  [NUM_ENTRIES];
  logic [OCC_W-1:0] r_occ;

  row_t             w_valid_n, w_issued_n, w_woken_n;
  row_t             w_dep_n [NUM_ENTRIES];
  logic [FU_W-1:0]  w_fu_n  [NUM_ENTRIES];
  logic [LAT_W-1:0] w_lat_n [NUM_ENTRIES];
  logic [LAT_W-1:0] w_cd_n  [NUM_ENTRIES];
  logic [OCC_W-1:0] w_occ_n;

  row_t                     w_ready, w_gnt_ent, w_wake, w_free, w_clr, w_new_dep, w_cancel;
  logic [NUM_FUS-1:0]       w_gnt_valid;
  logic [NUM_FUS*IDX_W-1:0] w_gnt_idx;
  logic                     w_disp_ready, w_disp_fire;
  logic [IDX_W-1:0]         w_disp_idx, w_tag;

`ifdef WAKEUP_REPLAY_EN
  row_t r_sdep   [NUM_ENTRIES];
  row_t w_sdep_n [NUM_ENTRIES];
  row_t w_new_sdep;

  always_comb begin
    w_cancel = '0;
    if (bus.cancel_valid) w_cancel[bus.cancel_idx] = 1'b1;
  end
`else
  assign w_cancel = '0;
`endif

  always_comb begin
    w_ready = '0;
    w_free  = '0;
    for (int e = 0; e < NUM_ENTRIES; e++)
      w_ready[e] = r_valid[e] & ~r_issued[e] & ~(|r_dep[e]);
    for (int f = 0; f < NUM_FUS; f++)
      if (bus.free_valid[f]) w_free[bus.free_idx[f*IDX_W +: IDX_W]] = 1'b1;
  end

  // Lowest-index ready entry per unstalled FU; descending scan leaves the lowest.
  always_comb begin
    w_gnt_valid = '0;
    w_gnt_idx   = '0;
    w_gnt_ent   = '0;
    for (int f = 0; f < NUM_FUS; f++) begin
      for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
        if (rst && !bus.fu_stall[f] && w_ready[e] && r_fu[e] == FU_W'(f)) begin
          w_gnt_valid[f]              = 1'b1;
          w_gnt_idx[f*IDX_W +: IDX_W] = IDX_W'(e);
        end
      end
      if (w_gnt_valid[f]) w_gnt_ent[w_gnt_idx[f*IDX_W +: IDX_W]] = 1'b1;
    end
  end

  // A latency-1 grant wakes at its own edge; longer ones count down to 1.
  always_comb begin
    w_wake = '0;
    for (int e = 0; e < NUM_ENTRIES; e++)
      w_wake[e] = (w_gnt_ent[e] && r_lat[e] <= C_LAT_ONE) || (r_cd[e] == C_LAT_ONE);
    w_clr = (w_wake | w_free) & ~w_cancel;
  end

  always_comb begin
    w_disp_idx = '0;
    w_tag      = '0;
    w_new_dep  = '0;
`ifdef WAKEUP_REPLAY_EN
    w_new_sdep = '0;
`endif
    for (int e = NUM_ENTRIES - 1; e >= 0; e--)
      if (!r_valid[e]) w_disp_idx = IDX_W'(e);
    w_disp_ready = rst & ~(&r_valid);
    w_disp_fire  = bus.disp_valid & w_disp_ready & ~bus.flush;
    for (int s = 0; s < NUM_SRCS; s++) begin
      if (bus.disp_src_en[s]) begin
        w_tag = bus.disp_src_tag[s*IDX_W +: IDX_W];
        if (r_valid[w_tag] && !r_woken[w_tag] && !w_clr[w_tag]) w_new_dep[w_tag] = 1'b1;
`ifdef WAKEUP_REPLAY_EN
        if (r_valid[w_tag] && !w_free[w_tag]) w_new_sdep[w_tag] = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    w_valid_n  = r_valid;
    w_issued_n = r_issued;
    w_woken_n  = r_woken;
    w_dep_n    = r_dep;
    w_fu_n     = r_fu;
    w_lat_n    = r_lat;
    w_cd_n     = r_cd;
    w_occ_n    = '0;
`ifdef WAKEUP_REPLAY_EN
    w_sdep_n   = r_sdep;
`endif
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      if (r_cd[e] != '0) w_cd_n[e] = r_cd[e] - C_LAT_ONE;
      if (w_gnt_ent[e]) begin
        w_issued_n[e] = 1'b1;
        w_cd_n[e]     = (r_lat[e] > C_LAT_ONE) ? r_lat[e] - C_LAT_ONE : '0;
      end
      if (w_clr[e]) begin
        w_woken_n[e] = 1'b1;
        for (int r = 0; r < NUM_ENTRIES; r++) w_dep_n[r][e] = 1'b0;
      end
      if (w_free[e]) begin
        w_valid_n[e]  = 1'b0;
        w_issued_n[e] = 1'b0;
        w_cd_n[e]     = '0;
`ifdef WAKEUP_REPLAY_EN
        w_sdep_n[e]   = '0;
        for (int r = 0; r < NUM_ENTRIES; r++) w_sdep_n[r][e] = 1'b0;
`endif
      end
    end
`ifdef WAKEUP_REPLAY_EN
    // Cancel overrides the producer's grant/wake and re-arms its direct consumers.
    if (bus.cancel_valid) begin
      w_issued_n[bus.cancel_idx] = 1'b0;
      w_woken_n[bus.cancel_idx]  = 1'b0;
      w_cd_n[bus.cancel_idx]     = '0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (r_valid[e] && !w_free[e] && r_sdep[e][bus.cancel_idx]) begin
          w_dep_n[e][bus.cancel_idx] = 1'b1;
          w_issued_n[e]              = 1'b0;
          w_cd_n[e]                  = '0;
        end
      end
    end
`endif
    if (w_disp_fire) begin
      w_valid_n[w_disp_idx]  = 1'b1;
      w_issued_n[w_disp_idx] = 1'b0;
      w_woken_n[w_disp_idx]  = 1'b0;
      w_fu_n[w_disp_idx]     = bus.disp_fu;
      w_lat_n[w_disp_idx]    = (bus.disp_lat == '0) ? C_LAT_ONE : bus.disp_lat;
      w_cd_n[w_disp_idx]     = '0;
      w_dep_n[w_disp_idx]    = w_new_dep;
`ifdef WAKEUP_REPLAY_EN
      w_sdep_n[w_disp_idx]   = w_new_sdep;
`endif
    end
    if (bus.flush) begin
      w_valid_n  = '0;
      w_issued_n = '0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        w_cd_n[e]  = '0;
        w_dep_n[e] = '0;
      end
    end
    for (int e = 0; e < NUM_ENTRIES; e++) w_occ_n = w_occ_n + OCC_W'(w_valid_n[e]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid  <= '0;
      r_issued <= '0;
      r_woken  <= '0;
      r_occ    <= '0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        r_dep[e]  <= '0;
        r_fu[e]   <= '0;
        r_lat[e]  <= '0;
        r_cd[e]   <= '0;
`ifdef WAKEUP_REPLAY_EN
        r_sdep[e] <= '0;
`endif
      end
    end else begin
      r_valid  <= w_valid_n;
      r_issued <= w_issued_n;
      r_woken  <= w_woken_n;
      r_occ    <= w_occ_n;
      r_dep    <= w_dep_n;
      r_fu     <= w_fu_n;
      r_lat    <= w_lat_n;
      r_cd     <= w_cd_n;
`ifdef WAKEUP_REPLAY_EN
      r_sdep   <= w_sdep_n;
`endif
    end
  end

  assign bus.disp_ready  = w_disp_ready;
  assign bus.disp_idx    = w_disp_idx;
  assign bus.grant_valid = w_gnt_valid;
  assign bus.grant_idx   = w_gnt_idx;
  assign bus.occupancy   = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_wakeup_select_matrix.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wakeup_select_matrix : scoreboard bench for the RS wakeup/select block |
// | Rev 1.0 ; replay scenario compiled in when WAKEUP_REPLAY_EN is defined    |
// +--------------------------------------------------------------------------+
module tb_wakeup_select_matrix;
  localparam int NE    = 16;
  localparam int NF    = 4;
  localparam int NS    = 2;
  localparam int LW    = 4;
  localparam int IDX_W = $clog2(NE);
  localparam int FU_W  = $clog2(NF);
  localparam int TAG_W = NS * IDX_W;

  localparam int K_GV   = 0;
  localparam int K_GI   = 1;
  localparam int K_OCC  = 2;
  localparam int K_RDY  = 3;
  localparam int K_DIDX = 4;

  typedef struct {
    int cyc;
    int kind;
    int fu;
    int val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];

  wakeup_select_matrix_if #(.NUM_ENTRIES(NE), .NUM_FUS(NF), .NUM_SRCS(NS), .LAT_W(LW)) bus ();

  wakeup_select_matrix #(.NUM_ENTRIES(NE), .NUM_FUS(NF), .NUM_SRCS(NS), .LAT_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind, input int fu);
    case (kind)
      K_GV:    return 32'(bus.grant_valid);
      K_GI:    return 32'(bus.grant_idx[fu*IDX_W +: IDX_W]);
      K_OCC:   return 32'(bus.occupancy);
      K_RDY:   return 32'(bus.disp_ready);
      default: return 32'(bus.disp_idx);
    endcase
  endfunction

  function automatic string kname(input int kind, input int fu);
    case (kind)
      K_GV:    return "grant_valid";
      K_GI:    return $sformatf("grant_idx%0d", fu);
      K_OCC:   return "occupancy";
      K_RDY:   return "disp_ready";
      default: return "disp_idx";
    endcase
  endfunction

  // Scoreboard drain: every expectation due this cycle is compared mid-cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        chk($sformatf("%s@%0d", kname(sb[i].kind, sb[i].fu), sb[i].cyc),
            observe(sb[i].kind, sb[i].fu), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic ex(input int dc, input int kind, input int fu, input int val);
    exp_t t;
    t.cyc  = cyc + dc;
    t.kind = kind;
    t.fu   = fu;
    t.val  = val;
    sb.push_back(t);
  endtask

  task automatic ex_gnt(input int dc, input int gv, input int fu, input int idx);
    ex(dc, K_GV, 0, gv);
    ex(dc, K_GI, fu, idx);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.disp_valid  = 1'b0;
    bus.disp_src_en = '0;
    bus.free_valid  = '0;
    bus.flush       = 1'b0;
`ifdef WAKEUP_REPLAY_EN
    bus.cancel_valid = 1'b0;
`endif
  endtask

  task automatic disp(input int fu, input int lat, input int en, input int t0);
    bus.disp_valid   = 1'b1;
    bus.disp_fu      = FU_W'(fu);
    bus.disp_lat     = LW'(lat);
    bus.disp_src_en  = NS'(en);
    bus.disp_src_tag = TAG_W'(t0);
  endtask

  task automatic fr(input int port, input int idx);
    bus.free_valid[port]               = 1'b1;
    bus.free_idx[port*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected normal end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b0;
    bus.flush        = 1'b0;
    bus.disp_valid   = 1'b0;
    bus.disp_fu      = '0;
    bus.disp_lat     = '0;
    bus.disp_src_en  = '0;
    bus.disp_src_tag = '0;
    bus.fu_stall     = '0;
    bus.free_valid   = '0;
    bus.free_idx     = '0;
`ifdef WAKEUP_REPLAY_EN
    bus.cancel_valid = 1'b0;
    bus.cancel_idx   = '0;
`endif
    @(posedge clk);
    #1;
    ex(0, K_RDY, 0, 0); ex(0, K_GV, 0, 0); ex(0, K_OCC, 0, 0); ex(0, K_DIDX, 0, 0);
    tick();
    rst = 1'b1;
    ex(0, K_RDY, 0, 1); ex(0, K_OCC, 0, 0); ex(0, K_GV, 0, 0);

    // Fill: each entry issues the cycle after dispatch on its own FU.
    for (int i = 0; i < NE; i++) begin
      ex(0, K_DIDX, 0, i); ex(0, K_RDY, 0, 1);
      disp(i % NF, 1, 0, 0);
      ex_gnt(1, 1 << (i % NF), i % NF, i);
      ex(1, K_OCC, 0, i + 1);
      tick();
    end
    ex(0, K_RDY, 0, 0);
    disp(0, 1, 0, 0);
    ex(1, K_OCC, 0, 16); ex(1, K_GV, 0, 0); ex(1, K_RDY, 0, 0);
    tick();

    // Two frees in one cycle; slots only reusable the next cycle.
    fr(0, 4); fr(1, 9);
    ex(0, K_RDY, 0, 0); ex(1, K_OCC, 0, 14); ex(1, K_RDY, 0, 1); ex(1, K_DIDX, 0, 4);
    tick();
    disp(0, 1, 0, 0);
    ex_gnt(1, 1, 0, 4); ex(1, K_DIDX, 0, 9); ex(1, K_OCC, 0, 15);
    tick();
    disp(1, 1, 0, 0);
    ex_gnt(1, 2, 1, 9); ex(1, K_OCC, 0, 16); ex(1, K_RDY, 0, 0);
    tick();
    fr(0, 10); fr(1, 11); fr(2, 12); fr(3, 13);
    ex(1, K_OCC, 0, 12); ex(1, K_DIDX, 0, 10);
    tick();
    fr(0, 14); fr(1, 15);
    ex(1, K_OCC, 0, 10);
    tick();
    bus.flush = 1'b1;
    disp(2, 1, 0, 0);
    ex(1, K_OCC, 0, 0); ex(1, K_GV, 0, 0); ex(1, K_DIDX, 0, 0); ex(1, K_RDY, 0, 1);
    tick();

    // Chain, latency 1: producer held by stall so the consumer sees a live dep.
    disp(0, 1, 0, 0); ex(0, K_DIDX, 0, 0);
    tick(); bus.fu_stall = 4'b0001;
    disp(1, 1, 1, 0); ex(0, K_GV, 0, 0); ex(0, K_DIDX, 0, 1);
    tick(); bus.fu_stall = 4'b0000;
    ex_gnt(0, 1, 0, 0); ex_gnt(1, 2, 1, 1);
    tick(); tick();
    fr(0, 0); fr(1, 1); ex(1, K_OCC, 0, 0);
    tick();

    // Chain, latency 3.
    disp(0, 3, 0, 0);
    tick(); bus.fu_stall = 4'b0001;
    disp(1, 1, 1, 0); ex(0, K_GV, 0, 0);
    tick(); bus.fu_stall = 4'b0000;
    ex_gnt(0, 1, 0, 0); ex(1, K_GV, 0, 0); ex(2, K_GV, 0, 0); ex_gnt(3, 2, 1, 1);
    tick(); tick(); tick(); tick();
    fr(0, 0); fr(1, 1); ex(1, K_OCC, 0, 0);
    tick();

    // Same-cycle race: consumer 3 dispatched before entry 2 wakes, consumer 4 during.
    disp(2, 1, 0, 0);
    tick();
    disp(2, 1, 0, 0); ex_gnt(0, 4, 2, 0);
    tick();
    disp(0, 3, 0, 0); ex_gnt(0, 4, 2, 1);
    tick();
    ex_gnt(0, 1, 0, 2);
    tick();
    disp(1, 1, 1, 2); ex(0, K_GV, 0, 0); ex(0, K_DIDX, 0, 3);
    tick();
    disp(2, 1, 1, 2); ex(0, K_GV, 0, 0); ex(0, K_DIDX, 0, 4);
    tick();
    ex(0, K_GV, 0, 6); ex(0, K_GI, 1, 3); ex(0, K_GI, 2, 4); ex(0, K_OCC, 0, 5);
    tick();
    bus.flush = 1'b1; ex(1, K_OCC, 0, 0);
    tick();

    // Stall with two ready fu1 entries; lowest index wins after release.
    disp(3, 1, 0, 0);
    tick();
    disp(3, 1, 0, 0); ex_gnt(0, 8, 3, 0);
    tick();
    disp(3, 1, 0, 0); ex_gnt(0, 8, 3, 1);
    tick();
    disp(1, 1, 0, 0); ex_gnt(0, 8, 3, 2);
    tick(); bus.fu_stall = 4'b0010;
    disp(2, 1, 0, 0); ex(0, K_GV, 0, 0);
    tick();
    disp(1, 1, 0, 0); ex_gnt(0, 4, 2, 4);
    tick();
    ex(0, K_GV, 0, 0);
    tick();
    ex(0, K_GV, 0, 0);
    tick(); bus.fu_stall = 4'b0000;
    ex_gnt(0, 2, 1, 3);
    tick();
    ex_gnt(0, 2, 1, 5); ex(0, K_OCC, 0, 6);
    tick();
    bus.flush = 1'b1; ex(1, K_OCC, 0, 0);
    tick();

`ifdef WAKEUP_REPLAY_EN
    // Replay: cancel load 0 in the cycle its dependent issues.
    disp(0, 3, 0, 0);
    tick();
    disp(1, 1, 1, 0);
    ex_gnt(0, 1, 0, 0); ex(1, K_GV, 0, 0); ex(2, K_GV, 0, 0); ex_gnt(3, 2, 1, 1);
    ex_gnt(4, 1, 0, 0); ex(5, K_GV, 0, 0); ex(6, K_GV, 0, 0); ex_gnt(7, 2, 1, 1);
    tick(); tick(); tick();
    bus.cancel_valid = 1'b1;
    bus.cancel_idx   = IDX_W'(0);
    tick(); tick(); tick(); tick(); tick();
`endif

    tick(); tick();
    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
